// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM command codes and arbiter state encoding shared by the SDRAM controller files.
package sdram_pkg;

    // Commands are {cs_n, ras_n, cas_n, we_n}.
    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_MODE_SELECT  = 4'b0000;
    localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
    localparam logic [3:0] CMD_WRITE        = 4'b0100;
    localparam logic [3:0] CMD_READ         = 4'b0101;
    localparam logic [3:0] CMD_BURST_STOP   = 4'b0110;

    typedef enum logic [4:0] {
        ST_INIT  = 5'b00001,
        ST_IDLE  = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } arb_state_t;

endpackage

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: owns the SDRAM command/address bus and hands it to init, refresh, write or read.
//   sys_clk, sys_rst (async, active-low)
//   init_*  : power-up initialiser bus and done flag (bus owner until done)
//   aref_*  : refresh request/end/bus, highest priority after init
//   wr_*    : write engine request/end/bus
//   rd_*    : read engine request/end/bus
//   *_en    : registered grant to each engine
//   sdram_* : SDRAM command pins, bank and address
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int CMD_W  = 4,
    parameter int ADDR_W = 12,
    parameter int BA_W   = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [CMD_W-1:0]  init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_end_flag,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [CMD_W-1:0]  aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [CMD_W-1:0]  wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [CMD_W-1:0]  rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr
);

    arb_state_t        state_q, state_d;
    logic              last_q;
    logic [CMD_W-1:0]  cmd;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  state_d = init_end_flag ? ST_IDLE : ST_INIT;
            // Refresh first; when both data engines wait, serve the one not served last.
            ST_IDLE:  state_d = aref_req          ? ST_AREF :
                                (wr_req && rd_req) ? (last_q ? ST_WRITE : ST_READ) :
                                wr_req            ? ST_WRITE :
                                rd_req            ? ST_READ : ST_IDLE;
            ST_AREF:  state_d = aref_end ? ST_IDLE : ST_AREF;
            ST_WRITE: state_d = wr_end ? ST_IDLE : ST_WRITE;
            ST_READ:  state_d = rd_end ? ST_IDLE : ST_READ;
            default:  state_d = ST_INIT;
        endcase
    end

    // Grants are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= ST_INIT;
            last_q  <= 1'b0;
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
        end else begin
            state_q <= state_d;
            aref_en <= state_d == ST_AREF;
            wr_en   <= state_d == ST_WRITE;
            rd_en   <= state_d == ST_READ;
            if (state_q == ST_IDLE && state_d == ST_WRITE)
                last_q <= 1'b0;
            if (state_q == ST_IDLE && state_d == ST_READ)
                last_q <= 1'b1;
        end
    end

    always_comb begin
        cmd        = CMD_NOP;
        sdram_ba   = '0;
        sdram_addr = '0;
        case (state_q)
            ST_INIT: begin
                cmd        = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                cmd        = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                cmd        = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                cmd        = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

endmodule
